frac_to_dec_seq: RTL and testbench
==================================

Name: frac_to_dec_seq

Overview:
- Sequential converter from a binary fraction (mantissa fraction field, weight 2^-1 down to 2^-FRAC_W) to NDIG packed-BCD decimal fraction digits.
- Digits are produced exactly, by repeated multiply-by-10, one digit per cycle, with a selectable final rounding step.
- Sits in the floating-point-to-decimal converter path and feeds the display/string stage.
- Valid/ready handshake on both sides. One conversion in flight at a time.

Parameters:
- FRAC_W, 23, width of the input fraction; must be >= 1.
- NDIG, 7, number of decimal digits produced; must be >= 1.
- RND_MODE, 1, rounding of the residue after the last digit: 0 = truncate, 1 = round-half-up, 2 = round-half-even.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  frac_in is valid.
- in_ready  out  1  block can accept a fraction; high only in IDLE.
- frac_in  in  FRAC_W  fraction bits; MSB has weight 2^-1.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- dec_bcd  out  4*NDIG  packed BCD digits; [4*NDIG-1:4*NDIG-4] is the first digit after the decimal point.
- carry_out  out  1  rounding overflowed to 1.000…; dec_bcd is then all zeros.
- inexact  out  1  residue was nonzero after NDIG digits, before rounding.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, dec_bcd=0, carry_out=0, inexact=0, internal residue and counter cleared. Any in-flight conversion is discarded with no output.
- FSM states: IDLE, CONV, RND, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load residue R := frac_in, digit counter := 0, dec_bcd := 0, carry_out := 0, inexact := 0;
  - go to CONV.
- CONV: in_ready=0. Each edge:
  - P = 10*R, formed as (R<<3)+(R<<1), width FRAC_W+4;
  - digit d = P[FRAC_W+3:FRAC_W], always 0..9;
  - R := P[FRAC_W-1:0];
  - dec_bcd := {dec_bcd[4*NDIG-5:0], d}, i.e. shift left by 4 with the new digit as the LSB digit;
  - counter increments. After the NDIG-th digit edge, go to RND.
- RND: one edge:
  - inexact := (R != 0);
  - round-up condition depends on RND_MODE:
    - mode 0: never;
    - mode 1: R[FRAC_W-1]=1;
    - mode 2: R > half, or R == half (R[FRAC_W-1]=1 and all other bits 0) and the last digit is odd.
  - On round-up, dec_bcd is incremented as BCD: a digit at 9 becomes 0 and carries into the next digit.
  - If the carry leaves the top digit, carry_out := 1 and dec_bcd = 0.
  - go to DONE.
- DONE: out_valid=1. dec_bcd, carry_out and inexact are stable. On an edge with out_ready=1, go to IDLE and out_valid := 0.
- in_valid is ignored outside IDLE; no input is accepted in the same cycle a result is released.
- Latency: if accepted at edge k, out_valid rises after edge k+NDIG+1.
- Minimum initiation interval: NDIG+3 cycles when out_ready is held high.
- Outputs are registered only; there is no combinational path from in_valid or out_ready to any output.
- frac_in = 0 yields all-zero digits, inexact=0, carry_out=0.

Test Plan:
- Defaults (23/7/1), frac_in=23'h400000 -> dec_bcd=0x5000000, inexact=0, carry_out=0; out_valid rises exactly 8 edges after accept.
- Defaults, frac_in=23'h7FFFFF (0.99999988…) -> truncated digits 9999998, rounded result 0x9999999, inexact=1, carry_out=0. Same input with RND_MODE=0 -> 0x9999998.
- FRAC_W=23, NDIG=1, RND_MODE=1, frac_in=23'h7FFFFF -> dec_bcd=0x0, carry_out=1, inexact=1.
- FRAC_W=4, NDIG=3, frac_in=4'b0001 (0.0625, residue exactly half):
  - RND_MODE=1 -> 0x063;
  - RND_MODE=2 -> 0x062;
  - frac_in=4'b0011 with RND_MODE=2 -> 0x188.
- Defaults, frac_in=23'h000001 -> 0x0000001, inexact=1.
- Back-pressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> IDLE on the next edge.
- Assert rst during the 3rd CONV cycle -> all outputs reach reset values immediately. A following conversion of 23'h400000 returns 0x5000000.

Source files
------------

// File: rtl/frac_to_dec_seq_if.sv
// frac_to_dec_seq_if: input/output valid-ready bundle for the fraction-to-decimal converter.
interface frac_to_dec_seq_if #(
    parameter int FRAC_W = 23,
    parameter int NDIG   = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W-1:0] frac_in;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] dec_bcd;
    logic              carry_out;
    logic              inexact;
    modport master (
        output in_valid, frac_in, out_ready,
        input  in_ready, out_valid, dec_bcd, carry_out, inexact
    );
    modport slave (
        input  in_valid, frac_in, out_ready,
        output in_ready, out_valid, dec_bcd, carry_out, inexact
    );
endinterface

// File: rtl/frac_to_dec_seq.sv
// frac_to_dec_seq: binary fraction to packed-BCD digits, one multiply-by-10 digit per cycle, then rounding.
module frac_to_dec_seq #(
    parameter int FRAC_W   = 23,
    parameter int NDIG     = 7,
    parameter int RND_MODE = 1
) (
    input logic              clk,
    input logic              rst,
    frac_to_dec_seq_if.slave bus
);
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [FRAC_W-1:0] HALF = FRAC_W'(1) << (FRAC_W - 1);
    typedef enum logic [1:0] {IDLE, CONV, RND, DONE} state_t;
    state_t            state_q;
    logic [FRAC_W-1:0] r_q;
    logic [CW-1:0]     cnt_q;
    logic [4*NDIG-1:0] dec_q;
    logic              in_ready_q, out_valid_q, carry_q, inexact_q;
    logic [FRAC_W+3:0] p;
    logic              up;
    logic [4*NDIG-1:0] inc_d;
    logic              inc_c;
    always_comb begin
        p = ({4'b0, r_q} << 3) + ({4'b0, r_q} << 1);
        up = RND_MODE == 1 ? r_q[FRAC_W-1] :
             RND_MODE == 2 ? (r_q > HALF) || (r_q == HALF && dec_q[0]) : 1'b0;
        inc_c = 1'b1;
        inc_d = dec_q;
        // BCD ripple increment; inc_c left set means every digit was 9
        for (int i = 0; i < NDIG; i++) begin
            inc_d[4*i +: 4] = inc_c && dec_q[4*i +: 4] == 4'd9 ? 4'd0 : dec_q[4*i +: 4] + {3'b0, inc_c};
            inc_c = inc_c && dec_q[4*i +: 4] == 4'd9;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            cnt_q       <= '0;
            dec_q       <= '0;
            carry_q     <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    r_q        <= bus.frac_in;
                    cnt_q      <= '0;
                    dec_q      <= '0;
                    carry_q    <= 1'b0;
                    inexact_q  <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= CONV;
                end
                CONV: begin
                    r_q   <= p[FRAC_W-1:0];
                    dec_q <= (dec_q << 4) | (4*NDIG)'(p[FRAC_W+3:FRAC_W]);
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) state_q <= RND;
                end
                RND: begin
                    inexact_q <= r_q != '0;
                    if (up) begin
                        dec_q   <= inc_d;
                        carry_q <= inc_c;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dec_bcd   = dec_q;
    assign bus.carry_out = carry_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_frac_to_dec_seq.sv
// tb_frac_to_dec_seq: random and directed conversions checked against an exact-arithmetic reference.
module tb_frac_to_dec_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic        ev = 1'b0;
    logic        er = 1'b0;
    logic [22:0] ef = '0;
    logic [3:0]  ef4 = '0;
    frac_to_dec_seq_if #(.FRAC_W(23), .NDIG(7)) if0 ();
    frac_to_dec_seq_if #(.FRAC_W(23), .NDIG(7)) if1 ();
    frac_to_dec_seq_if #(.FRAC_W(23), .NDIG(1)) if2 ();
    frac_to_dec_seq_if #(.FRAC_W(4),  .NDIG(3)) if3 ();
    frac_to_dec_seq_if #(.FRAC_W(4),  .NDIG(3)) if4 ();
    frac_to_dec_seq_if #(.FRAC_W(23), .NDIG(7)) if5 ();
    frac_to_dec_seq #(.FRAC_W(23), .NDIG(7), .RND_MODE(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    frac_to_dec_seq #(.FRAC_W(23), .NDIG(7), .RND_MODE(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    frac_to_dec_seq #(.FRAC_W(23), .NDIG(1), .RND_MODE(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    frac_to_dec_seq #(.FRAC_W(4),  .NDIG(3), .RND_MODE(1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    frac_to_dec_seq #(.FRAC_W(4),  .NDIG(3), .RND_MODE(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    frac_to_dec_seq #(.FRAC_W(23), .NDIG(7), .RND_MODE(2)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));
    assign if1.in_valid = ev;
    assign if1.frac_in = ef;
    assign if1.out_ready = er;
    assign if2.in_valid = ev;
    assign if2.frac_in = ef;
    assign if2.out_ready = er;
    assign if3.in_valid = ev;
    assign if3.frac_in = ef4;
    assign if3.out_ready = er;
    assign if4.in_valid = ev;
    assign if4.frac_in = ef4;
    assign if4.out_ready = er;
    assign if5.in_valid = ev;
    assign if5.frac_in = ef;
    assign if5.out_ready = er;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact value: floor(f * 10^nd / 2^fw) with the remainder deciding the rounding
    function automatic void model(input int fw, input int nd, input int mode, input longint f,
                                  output longint bcd, output longint cy, output longint inx);
        longint p10, prod, q, r, half;
        logic   up;
        p10 = 1;
        for (int i = 0; i < nd; i++) p10 = p10 * 10;
        prod = f * p10;
        q = prod >> fw;
        r = prod - (q << fw);
        half = longint'(1) << (fw - 1);
        up = mode == 1 ? r >= half : mode == 2 ? (r > half || (r == half && q % 2 == 1)) : 1'b0;
        inx = longint'(r != 0);
        q = q + longint'(up);
        cy = longint'(q == p10);
        if (cy != 0) q = 0;
        bcd = 0;
        for (int i = 0; i < nd; i++) begin
            bcd = bcd | ((q % 10) << (4 * i));
            q = q / 10;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic conv_main(input logic [22:0] f);
        longint b, c, x;
        int     n;
        model(23, 7, 1, longint'(f), b, c, x);
        if0.in_valid = 1'b1;
        if0.frac_in = f;
        tick;
        if0.in_valid = 1'b0;
        chk("busy", longint'(if0.in_ready), 0);
        n = 0;
        while (!if0.out_valid && n < 40) begin
            tick;
            n++;
        end
        chk("latency", longint'(n), 8);
        chk("dec", longint'(if0.dec_bcd), b);
        chk("carry", longint'(if0.carry_out), c);
        chk("inexact", longint'(if0.inexact), x);
        if0.out_ready = 1'b1;
        tick;
        if0.out_ready = 1'b0;
        chk("release", longint'({if0.out_valid, if0.in_ready}), 1);
    endtask

    task automatic conv_ext(input logic [22:0] f, input logic [3:0] f4);
        longint b, c, x;
        ev = 1'b1;
        ef = f;
        ef4 = f4;
        tick;
        ev = 1'b0;
        repeat (10) tick;
        chk("ext valid", longint'({if1.out_valid, if2.out_valid, if3.out_valid, if4.out_valid, if5.out_valid}), 31);
        model(23, 7, 0, longint'(f), b, c, x);
        chk("trunc dec", longint'(if1.dec_bcd), b);
        chk("trunc flags", longint'({if1.carry_out, if1.inexact}), (c << 1) | x);
        model(23, 1, 1, longint'(f), b, c, x);
        chk("ndig1 dec", longint'(if2.dec_bcd), b);
        chk("ndig1 flags", longint'({if2.carry_out, if2.inexact}), (c << 1) | x);
        model(4, 3, 1, longint'(f4), b, c, x);
        chk("w4 half-up dec", longint'(if3.dec_bcd), b);
        chk("w4 half-up flags", longint'({if3.carry_out, if3.inexact}), (c << 1) | x);
        model(4, 3, 2, longint'(f4), b, c, x);
        chk("w4 half-even dec", longint'(if4.dec_bcd), b);
        chk("w4 half-even flags", longint'({if4.carry_out, if4.inexact}), (c << 1) | x);
        model(23, 7, 2, longint'(f), b, c, x);
        chk("half-even dec", longint'(if5.dec_bcd), b);
        chk("half-even flags", longint'({if5.carry_out, if5.inexact}), (c << 1) | x);
        er = 1'b1;
        tick;
        er = 1'b0;
    endtask

    initial begin
        longint b, c, x;
        logic [22:0] f;
        if0.in_valid = 1'b0;
        if0.frac_in = '0;
        if0.out_ready = 1'b0;
        tick;
        tick;
        chk("reset ctl", longint'({if0.in_ready, if0.out_valid, if0.carry_out, if0.inexact}), 8);
        chk("reset dec", longint'(if0.dec_bcd), 0);
        rst = 1'b0;
        tick;
        conv_main(23'h400000);
        conv_main(23'h7FFFFF);
        conv_main(23'h000001);
        conv_main(23'h000000);
        repeat (25) conv_main($urandom_range(0, 3) == 0 ? 23'($urandom_range(0, 255)) : 23'($urandom));
        // back-pressure with a competing request
        f = 23'($urandom);
        model(23, 7, 1, longint'(f), b, c, x);
        if0.in_valid = 1'b1;
        if0.frac_in = f;
        tick;
        if0.in_valid = 1'b0;
        repeat (8) tick;
        for (int i = 0; i < 10; i++) begin
            if0.in_valid = 1'b1;
            if0.frac_in = 23'h400000;
            tick;
            chk("bp ctl", longint'({if0.in_ready, if0.out_valid}), 1);
            chk("bp dec", longint'(if0.dec_bcd), b);
            chk("bp flags", longint'({if0.carry_out, if0.inexact}), (c << 1) | x);
        end
        if0.out_ready = 1'b1;
        tick;
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b0;
        chk("bp release", longint'({if0.in_ready, if0.out_valid}), 2);
        tick;
        chk("no accept on release", longint'(if0.in_ready), 1);
        // asynchronous reset in the third CONV cycle
        if0.in_valid = 1'b1;
        if0.frac_in = 23'h7FFFFF;
        tick;
        if0.in_valid = 1'b0;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("async rst ctl", longint'({if0.in_ready, if0.out_valid, if0.carry_out, if0.inexact}), 8);
        chk("async rst dec", longint'(if0.dec_bcd), 0);
        #1 rst = 1'b0;
        tick;
        conv_main(23'h400000);
        conv_ext(23'h7FFFFF, 4'b0001);
        conv_ext(23'h000001, 4'b0011);
        conv_ext(23'h400000, 4'b1000);
        repeat (10) conv_ext(23'($urandom), 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
